// File: rtl/seq_pattern_tx.sv
// Bit-serial MSB-first pattern transmitter with frame repeat and done pulse.
// Optional per-frame even-parity bit enabled by defining SEQ_TX_PARITY_EN.
module seq_pattern_tx #(
    parameter int WIDTH = 5,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pat_in,
    input  logic [REP_W-1:0] rep,
    output logic             j,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef SEQ_TX_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_hold;
    logic [REP_W-1:0] r_frames;
    logic [CNT_W-1:0] r_bitcnt;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [WIDTH-1:0] w_hold_nxt;
    logic [REP_W-1:0] w_frames_nxt;
    logic [CNT_W-1:0] w_bitcnt_nxt;
    logic             w_bit;

`ifdef SEQ_TX_PARITY_EN
    // Past the last pattern bit the shifter is empty; send parity instead.
    assign w_bit = (r_bitcnt == CNT_W'(WIDTH)) ? ^r_hold
                                               : r_shreg[WIDTH-1];
`else
    assign w_bit = r_shreg[WIDTH-1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_shreg  <= '0;
            r_hold   <= '0;
            r_frames <= '0;
            r_bitcnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_shreg  <= w_shreg_nxt;
            r_hold   <= w_hold_nxt;
            r_frames <= w_frames_nxt;
            r_bitcnt <= w_bitcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shreg_nxt  = r_shreg;
        w_hold_nxt   = r_hold;
        w_frames_nxt = r_frames;
        w_bitcnt_nxt = r_bitcnt;
        j            = 1'b0;
        valid        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_shreg_nxt  = pat_in;
                    w_hold_nxt   = pat_in;
                    w_frames_nxt = (rep == '0) ? REP_W'(1) : rep;
                    w_bitcnt_nxt = '0;
                    w_state_nxt  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                j            = w_bit;
                valid        = 1'b1;
                busy         = 1'b1;
                w_shreg_nxt  = {r_shreg[WIDTH-2:0], 1'b0};
                w_bitcnt_nxt = r_bitcnt + CNT_W'(1);
                if (r_bitcnt == LAST) begin
                    if (r_frames > REP_W'(1)) begin
                        w_frames_nxt = r_frames - REP_W'(1);
                        w_shreg_nxt  = r_hold;
                        w_bitcnt_nxt = '0;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
